// File: rtl/bus_demux4.sv
// ---------------------------------------------------------------------------
// bus_demux4
//
// 1-to-4 data-bus demultiplexer between the core data port and four slaves
// (RAM, UART, CLINT, PLIC). A request is accepted in IDLE and its address is
// decoded against four base/mask regions. The latched request goes to the
// selected slave, and that slave's response returns to the CPU as a single
// pulse. Only one transaction is outstanding at a time.
//
// Optional feature (macro BUS_DEMUX4_TIMEOUT_EN):
//   When defined, a watchdog aborts a transaction that spends TIMEOUT_CYCLES
//   cycles in SEND/WAIT and returns an error response. When undefined, no
//   counter is built and SEND/WAIT wait indefinitely.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   m_req_valid/ready  CPU request handshake (ready only in IDLE)
//   m_req_addr/write/wdata/strobe  CPU request fields
//   m_resp_valid       one-cycle response pulse
//   m_resp_data/err    response data (0 for stores/errors), error flag
//   s_req_valid[3:0]   one-hot request valid, bit i = slave i
//   s_req_ready[3:0]   per-slave accept
//   s_req_addr/write/wdata/strobe  latched request fields, shared
//   s_resp_valid[3:0]  per-slave response valid
//   s_resp_data[255:0] slave i data on bits [64i+63:64i]
// ---------------------------------------------------------------------------
module bus_demux4 #(
  parameter logic [63:0] BASE0 = 64'h0000_0000_8000_0000,
  parameter logic [63:0] MASK0 = 64'hFFFF_FFFF_F000_0000,
  parameter logic [63:0] BASE1 = 64'h0000_0000_4000_0000,
  parameter logic [63:0] MASK1 = 64'hFFFF_FFFF_FFFF_F000,
  parameter logic [63:0] BASE2 = 64'h0000_0000_0200_0000,
  parameter logic [63:0] MASK2 = 64'hFFFF_FFFF_FFFF_0000,
  parameter logic [63:0] BASE3 = 64'h0000_0000_0C00_0000,
  parameter logic [63:0] MASK3 = 64'hFFFF_FFFF_FC00_0000,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic         clk,
  input  logic         reset,
  // CPU side
  input  logic         m_req_valid,
  output logic         m_req_ready,
  input  logic [63:0]  m_req_addr,
  input  logic         m_req_write,
  input  logic [63:0]  m_req_wdata,
  input  logic [7:0]   m_req_strobe,
  output logic         m_resp_valid,
  output logic [63:0]  m_resp_data,
  output logic         m_resp_err,
  // Slave side
  output logic [3:0]   s_req_valid,
  input  logic [3:0]   s_req_ready,
  output logic [63:0]  s_req_addr,
  output logic         s_req_write,
  output logic [63:0]  s_req_wdata,
  output logic [7:0]   s_req_strobe,
  input  logic [3:0]   s_resp_valid,
  input  logic [255:0] s_resp_data
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    WAIT = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Latched request and target
  logic [63:0] addr_q;
  logic        write_q;
  logic [63:0] wdata_q;
  logic [7:0]  strobe_q;
  logic [1:0]  tgt_q;

  // Registered response, held between pulses
  logic [63:0] rdata_q;
  logic        err_q;

  // Address decode of the incoming request
  logic        dec_hit;
  logic [1:0]  dec_idx;

  // Target-selected views of the slave inputs
  logic        tgt_ready;
  logic        tgt_resp;
  logic [63:0] tgt_data;

  logic        timeout;

  // Region i hits when (addr & MASKi) == BASEi. Lower index wins on overlap.
  function automatic logic [2:0] decode(input logic [63:0] a);
    logic [2:0] r;
    r = 3'b000;
    if ((a & MASK0) == BASE0)      r = {1'b1, 2'd0};
    else if ((a & MASK1) == BASE1) r = {1'b1, 2'd1};
    else if ((a & MASK2) == BASE2) r = {1'b1, 2'd2};
    else if ((a & MASK3) == BASE3) r = {1'b1, 2'd3};
    return r;
  endfunction

  always_comb begin
    {dec_hit, dec_idx} = decode(m_req_addr);
  end

  // Only the latched target's handshake bits matter; the others are ignored.
  always_comb begin
    tgt_ready = s_req_ready[tgt_q];
    tgt_resp  = s_resp_valid[tgt_q];
    tgt_data  = s_resp_data[{tgt_q, 6'd0} +: 64];
  end

`ifdef BUS_DEMUX4_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;

  // SEND is entered only from IDLE, so clearing in IDLE clears on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state == IDLE) begin
      to_cnt <= '0;
    end else if (state == SEND || state == WAIT) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  // Fires during the TIMEOUT_CYCLES-th cycle spent in SEND/WAIT.
  always_comb begin
    timeout = (state == SEND || state == WAIT) &&
              (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end
`else
  logic unused_timeout_cfg;

  always_comb begin
    timeout            = 1'b0;
    unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  end
`endif

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m_req_valid) begin
          state_nxt = dec_hit ? SEND : ERR;
        end
      end
      SEND: begin
        // An accept in the timeout cycle is still aborted: no response has arrived.
        if (timeout) begin
          state_nxt = ERR;
        end else if (tgt_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A response arriving in the timeout cycle completes normally.
        if (tgt_resp) begin
          state_nxt = RESP;
        end else if (timeout) begin
          state_nxt = ERR;
        end
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- request latch and response register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strobe_q <= '0;
      tgt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == IDLE && m_req_valid) begin
        addr_q   <= m_req_addr;
        write_q  <= m_req_write;
        wdata_q  <= m_req_wdata;
        strobe_q <= m_req_strobe;
        tgt_q    <= dec_idx;
      end
      // RESP and ERR last one cycle, so these loads occur once per transaction.
      if (state_nxt == RESP) begin
        rdata_q <= write_q ? 64'd0 : tgt_data;
        err_q   <= 1'b0;
      end else if (state_nxt == ERR) begin
        rdata_q <= 64'd0;
        err_q   <= 1'b1;
      end
    end
  end

  // ---- output logic ----
  always_comb begin
    m_req_ready  = (state == IDLE);
    m_resp_valid = (state == RESP) || (state == ERR);
    m_resp_data  = rdata_q;
    m_resp_err   = err_q;
    s_req_valid  = (state == SEND) ? (4'b0001 << tgt_q) : 4'b0000;
    s_req_addr   = addr_q;
    s_req_write  = write_q;
    s_req_wdata  = wdata_q;
    s_req_strobe = strobe_q;
  end

endmodule

// File: tb/tb_bus_demux4.sv
// ---------------------------------------------------------------------------
// tb_bus_demux4
//
// Directed bench for bus_demux4. Expected responses are queued when a request
// is issued and popped when the demux pulses m_resp_valid. Define
// BUS_DEMUX4_TIMEOUT_EN to build both DUT and bench with an 8-cycle watchdog.
// ---------------------------------------------------------------------------
module tb_bus_demux4;

`ifdef BUS_DEMUX4_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif

  logic         clk;
  logic         reset;
  logic         m_req_valid;
  logic         m_req_ready;
  logic [63:0]  m_req_addr;
  logic         m_req_write;
  logic [63:0]  m_req_wdata;
  logic [7:0]   m_req_strobe;
  logic         m_resp_valid;
  logic [63:0]  m_resp_data;
  logic         m_resp_err;
  logic [3:0]   s_req_valid;
  logic [3:0]   s_req_ready;
  logic [63:0]  s_req_addr;
  logic         s_req_write;
  logic [63:0]  s_req_wdata;
  logic [7:0]   s_req_strobe;
  logic [3:0]   s_resp_valid;
  logic [255:0] s_resp_data;

  bus_demux4 #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .m_req_valid  (m_req_valid),
    .m_req_ready  (m_req_ready),
    .m_req_addr   (m_req_addr),
    .m_req_write  (m_req_write),
    .m_req_wdata  (m_req_wdata),
    .m_req_strobe (m_req_strobe),
    .m_resp_valid (m_resp_valid),
    .m_resp_data  (m_resp_data),
    .m_resp_err   (m_resp_err),
    .s_req_valid  (s_req_valid),
    .s_req_ready  (s_req_ready),
    .s_req_addr   (s_req_addr),
    .s_req_write  (s_req_write),
    .s_req_wdata  (s_req_wdata),
    .s_req_strobe (s_req_strobe),
    .s_resp_valid (s_resp_valid),
    .s_resp_data  (s_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } resp_t;

  resp_t sb[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled at the negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_lanes(input logic [63:0] base);
    for (int i = 0; i < 4; i++) begin
      s_resp_data[i*64 +: 64] = base + 64'(i);
    end
  endtask

  // Present a request for one cycle (cycle 0), then scramble the bus so that
  // the slave-side fields can only be correct if they were latched.
  task automatic issue(input logic [63:0] addr, input logic wr,
                       input logic [63:0] wd, input logic [7:0] st,
                       input bit push, input logic [63:0] ed, input logic ee);
    resp_t r;
    m_req_valid  = 1'b1;
    m_req_addr   = addr;
    m_req_write  = wr;
    m_req_wdata  = wd;
    m_req_strobe = st;
    if (push) begin
      r.data = ed;
      r.err  = ee;
      sb.push_back(r);
    end
    step();
    m_req_valid  = 1'b0;
    m_req_addr   = ~addr;
    m_req_write  = ~wr;
    m_req_wdata  = ~wd;
    m_req_strobe = ~st;
  endtask

  task automatic expect_resp(input string tag);
    resp_t r;
    chk({tag, " resp_valid"}, 64'(m_resp_valid), 64'd1);
    if (m_resp_valid === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL %s sb: observed unexpected response, expected none pending", tag);
      end
      if (sb.size() > 0) begin
        r = sb.pop_front();
        chk({tag, " resp_data"}, m_resp_data, r.data);
        chk({tag, " resp_err"}, 64'(m_resp_err), 64'(r.err));
      end
    end
  endtask

  // Best-case load: ready in cycle 1, response in cycle 2, pulse in cycle 3.
  task automatic do_read(input string tag, input logic [63:0] addr,
                         input logic [3:0] onehot, input int idx,
                         input logic [63:0] data);
    issue(addr, 1'b0, 64'h0, 8'hFF, 1'b1, data, 1'b0);
    chk({tag, " s_req_valid"}, 64'(s_req_valid), 64'(onehot));
    chk({tag, " m_req_ready busy"}, 64'(m_req_ready), 64'd0);
    chk({tag, " s_req_addr"}, s_req_addr, addr);
    s_req_ready = onehot;
    step();
    chk({tag, " wait no valid"}, 64'(s_req_valid), 64'd0);
    chk({tag, " wait no resp"}, 64'(m_resp_valid), 64'd0);
    s_req_ready  = 4'b0000;
    s_resp_valid = onehot;
    fill_lanes(64'h5A5A_0000_0000_0000);
    s_resp_data[idx*64 +: 64] = data;
    step();
    s_resp_valid = 4'b0000;
    expect_resp(tag);
    step();
    chk({tag, " pulse one cycle"}, 64'(m_resp_valid), 64'd0);
    chk({tag, " ready again"}, 64'(m_req_ready), 64'd1);
    chk({tag, " data held"}, m_resp_data, data);
  endtask

  initial begin
    logic seen;
    reset        = 1'b1;
    m_req_valid  = 1'b0;
    m_req_addr   = '0;
    m_req_write  = 1'b0;
    m_req_wdata  = '0;
    m_req_strobe = '0;
    s_req_ready  = '0;
    s_resp_valid = '0;
    s_resp_data  = '0;
    @(negedge clk);
    step();
    step();

    // Reset state
    chk("rst m_req_ready", 64'(m_req_ready), 64'd1);
    chk("rst s_req_valid", 64'(s_req_valid), 64'd0);
    chk("rst m_resp_valid", 64'(m_resp_valid), 64'd0);
    chk("rst m_resp_err", 64'(m_resp_err), 64'd0);
    chk("rst m_resp_data", m_resp_data, 64'd0);
    chk("rst s_req_addr", s_req_addr, 64'd0);
    reset = 1'b0;
    step();

    // RAM load, best-case latency
    do_read("ram", 64'h0000_0000_8000_1000, 4'b0001, 0, 64'h0000_0000_DEAD_BEEF);

    // Unmapped address: error pulse in cycle 1, data forced to 0
    issue(64'h0000_0000_1000_0000, 1'b0, 64'h0, 8'hFF, 1'b1, 64'd0, 1'b1);
    chk("unmapped s_req_valid", 64'(s_req_valid), 64'd0);
    chk("unmapped m_req_ready", 64'(m_req_ready), 64'd0);
    expect_resp("unmapped");
    step();
    chk("unmapped ready cycle2", 64'(m_req_ready), 64'd1);
    chk("unmapped pulse end", 64'(m_resp_valid), 64'd0);

    // UART store, slave ready after 3 cycles, fields stable, data 0
    issue(64'h0000_0000_4000_0004, 1'b1, 64'h41, 8'h01, 1'b1, 64'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("uart s_req_valid", 64'(s_req_valid), 64'b0010);
      chk("uart s_req_addr", s_req_addr, 64'h0000_0000_4000_0004);
      chk("uart s_req_wdata", s_req_wdata, 64'h41);
      chk("uart s_req_strobe", 64'(s_req_strobe), 64'h01);
      chk("uart s_req_write", 64'(s_req_write), 64'd1);
      s_req_ready = (k == 2) ? 4'b0010 : 4'b1101;
      step();
    end
    s_req_ready  = 4'b0000;
    chk("uart wait", 64'(s_req_valid), 64'd0);
    s_resp_valid = 4'b0010;
    fill_lanes(64'h0000_0000_0000_1234);
    step();
    s_resp_valid = 4'b0000;
    expect_resp("uart");
    step();

    // CLINT load
    do_read("clint", 64'h0000_0000_0200_BFF8, 4'b0100, 2, 64'h0123_4567_89AB_CDEF);

    // PLIC load with a spurious response from slave 2 while waiting
    issue(64'h0000_0000_0C00_0010, 1'b0, 64'h0, 8'hFF, 1'b1, 64'h0000_0000_0000_CAFE, 1'b0);
    chk("plic s_req_valid", 64'(s_req_valid), 64'b1000);
    s_req_ready = 4'b1000;
    step();
    s_req_ready  = 4'b0000;
    s_resp_valid = 4'b0100;
    s_resp_data  = '0;
    s_resp_data[2*64 +: 64] = 64'hBAD;
    step();
    chk("plic spurious ignored", 64'(m_resp_valid), 64'd0);
    s_resp_valid = 4'b1000;
    s_resp_data[3*64 +: 64] = 64'h0000_0000_0000_CAFE;
    step();
    s_resp_valid = 4'b0000;
    expect_resp("plic");
    step();

    // Reset during WAIT, then a late response from slave 0
    issue(64'h0000_0000_8000_0040, 1'b0, 64'h0, 8'hFF, 1'b0, 64'd0, 1'b0);
    s_req_ready = 4'b0001;
    step();
    s_req_ready = 4'b0000;
    reset       = 1'b1;
    step();
    reset        = 1'b0;
    s_resp_valid = 4'b0001;
    s_resp_data  = '0;
    s_resp_data[63:0] = 64'h77;
    chk("rstwait m_req_ready", 64'(m_req_ready), 64'd1);
    chk("rstwait s_req_addr", s_req_addr, 64'd0);
    chk("rstwait resp", 64'(m_resp_valid), 64'd0);
    step();
    s_resp_valid = 4'b0000;
    chk("rstwait late resp", 64'(m_resp_valid), 64'd0);
    chk("rstwait idle", 64'(m_req_ready), 64'd1);
    step();
    chk("rstwait data", m_resp_data, 64'd0);
    chk("rstwait no pulse", 64'(m_resp_valid), 64'd0);

    // Slave never ready
    seen = 1'b0;
`ifdef BUS_DEMUX4_TIMEOUT_EN
    issue(64'h0000_0000_8000_2000, 1'b0, 64'h0, 8'hFF, 1'b1, 64'd0, 1'b1);
    for (int c = 1; c <= TO; c++) begin
      seen = seen | (m_resp_valid === 1'b1);
      if (c == TO) chk("timeout still sending", 64'(s_req_valid), 64'b0001);
      step();
    end
    chk("timeout no early resp", 64'(seen), 64'd0);
    expect_resp("timeout");
    chk("timeout drops valid", 64'(s_req_valid), 64'd0);
    step();
    s_resp_valid = 4'b0001;
    chk("timeout idle", 64'(m_req_ready), 64'd1);
    step();
    s_resp_valid = 4'b0000;
    chk("timeout late resp", 64'(m_resp_valid), 64'd0);
`else
    issue(64'h0000_0000_8000_2000, 1'b0, 64'h0, 8'hFF, 1'b0, 64'd0, 1'b0);
    for (int c = 1; c < 100; c++) begin
      seen = seen | (m_resp_valid === 1'b1);
      step();
    end
    chk("stall s_req_valid c100", 64'(s_req_valid), 64'b0001);
    chk("stall no resp", 64'(seen), 64'd0);
    chk("stall m_req_ready", 64'(m_req_ready), 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("stall recovered", 64'(m_req_ready), 64'd1);
`endif
    step();

    // Normal operation after the abort
    do_read("ram2", 64'h0000_0000_8FFF_FFF8, 4'b0001, 0, 64'hFEED_FACE_0000_0001);

    chk("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
